// File: rtl/mem_port_scheduler_pkg.sv
// Shared types and constants for the unified memory port scheduler.
//   state_t     : scheduler FSM states (idle, serving data, serving fetch, halted)
//   grant_t     : which requester owns / last owned the memory port
//   FUNCT3_WORD : funct3 code for a full 32-bit word access, used for fetches
//   pick_grant  : arbitration rule between the fetch and data requesters
package mem_port_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_FETCH  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // A lone requester always wins. On a tie, the requester that was not served
  // last gets the port, so neither side can starve the other.
  function automatic grant_t pick_grant(input logic   if_req,
                                        input logic   d_req,
                                        input grant_t last_grant);
    grant_t sel;
    if (if_req && d_req) begin
      if (last_grant == GRANT_DATA) sel = GRANT_FETCH;
      else                          sel = GRANT_DATA;
    end else if (d_req) begin
      sel = GRANT_DATA;
    end else begin
      sel = GRANT_FETCH;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_port_scheduler_counter.sv
// mem_lat_counter: loadable down-counter that times one memory access.
//   clk      : clock
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value loaded at the start of an access
//   dec      : count down by one; holds at zero, never wraps
//   zero     : count is zero (last cycle of the access)
module mem_lat_counter
  import mem_port_scheduler_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: clocked state is written with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: time-shares a single-ported unified memory between
// instruction fetches and data loads/stores, stalls the pipeline while either
// side waits, and parks in a sticky halted state on the Halt control bit.
//   clk, rst                 : clock, asynchronous active-high reset
//   if_req/if_addr           : fetch request (held until if_ready) and PC
//   if_rdata/if_ready        : fetched word, valid during the 1-cycle ready pulse
//   d_read/d_write           : load/store request (held until d_ready)
//   d_addr/d_wdata/d_funct3  : data address, store data, access size/sign
//   d_rdata/d_ready          : load data, valid during the 1-cycle ready pulse
//   halt_in                  : Halt control bit from MEM/WB
//   mem_en/mem_we/mem_addr/mem_wdata/mem_funct3 : registered memory request
//   mem_rdata                : memory read data, valid in the last enabled cycle
//   stall                    : freeze PC and pipeline registers
//   halted                   : core halted (sticky until reset)
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [2:0]    d_funct3,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  input  logic          halt_in,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic [31:0]   mem_rdata,
  output logic          stall,
  output logic          halted
);

  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_t state, state_nx;
  grant_t last_grant, grant_sel;
  logic   d_req;
  logic   grant;
  logic   in_access;
  logic   done;
  logic   cnt_zero;
  logic   halt_pend;
  logic   we_q;

  // A store wins over a load if both control bits are set.
  assign d_req     = d_read | d_write;
  assign in_access = (state == ST_DATA) || (state == ST_FETCH);
  assign done      = in_access && cnt_zero;

  mem_lat_counter #(.W(CW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .load_val (CNT_LOAD),
    .dec      (in_access),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nx  = state;
    grant     = 1'b0;
    grant_sel = pick_grant(if_req, d_req, last_grant);
    case (state)
      ST_IDLE: begin
        if (halt_in) begin
          state_nx = ST_HALTED;
        end else if (if_req || d_req) begin
          grant    = 1'b1;
          state_nx = (grant_sel == GRANT_DATA) ? ST_DATA : ST_FETCH;
        end
      end
      ST_DATA, ST_FETCH: begin
        // A halt seen during the access is honoured once the access is done.
        if (cnt_zero) state_nx = (halt_pend || halt_in) ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: state_nx = ST_HALTED;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Request latches, ready pulses and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these registers drive module outputs directly, so they are all
      // reset to give the memory and pipeline a defined view out of reset.
      last_grant <= GRANT_FETCH;
      halt_pend  <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= FUNCT3_WORD;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (grant) begin
        halt_pend <= 1'b0;
        if (grant_sel == GRANT_DATA) begin
          mem_addr   <= d_addr;
          mem_wdata  <= d_wdata;
          mem_funct3 <= d_funct3;
          we_q       <= d_write;
        end else begin
          mem_addr   <= if_addr;
          mem_funct3 <= FUNCT3_WORD;
          we_q       <= 1'b0;
        end
      end

      if (in_access && halt_in) halt_pend <= 1'b1;

      if (done) begin
        we_q <= 1'b0;
        if (state == ST_DATA) begin
          d_ready    <= 1'b1;
          d_rdata    <= mem_rdata;
          last_grant <= GRANT_DATA;
        end else begin
          if_ready   <= 1'b1;
          if_rdata   <= mem_rdata;
          last_grant <= GRANT_FETCH;
        end
      end
    end
  end

  // Outputs decoded from state; mem_en/mem_we depend only on registers, so
  // the memory never sees a combinational path from the requesters.
  always_comb begin
    mem_en = in_access;
    mem_we = in_access & we_q;
    halted = (state == ST_HALTED);
    stall  = (state == ST_HALTED) | (if_req & ~if_ready) | (d_req & ~d_ready);
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench for mem_port_scheduler: directed sequences, a vector
// table on a MEM_LAT=1 instance, and randomized traffic against a
// transaction-timeline reference model on a MEM_LAT=2 instance.
module tb_mem_port_scheduler;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // MEM_LAT=2 instance signals
  logic        if_req, d_read, d_write, halt_in;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0]  d_funct3;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_en, mem_we, stall, halted;
  logic [2:0]  mem_funct3;

  // MEM_LAT=1 instance signals
  logic        if_req_1, d_read_1, d_write_1, halt_in_1;
  logic [31:0] if_addr_1, d_addr_1, d_wdata_1, mem_rdata_1;
  logic [2:0]  d_funct3_1;
  logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;
  logic        if_ready_1, d_ready_1, mem_en_1, mem_we_1, stall_1, halted_1;
  logic [2:0]  mem_funct3_1;

  mem_port_scheduler #(.MEM_LAT(2), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_rdata(d_rdata), .d_ready(d_ready),
    .halt_in(halt_in), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .stall(stall), .halted(halted)
  );

  mem_port_scheduler #(.MEM_LAT(1), .AW(32)) dut_1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
    .d_read(d_read_1), .d_write(d_write_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
    .d_funct3(d_funct3_1), .d_rdata(d_rdata_1), .d_ready(d_ready_1),
    .halt_in(halt_in_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_funct3(mem_funct3_1), .mem_rdata(mem_rdata_1),
    .stall(stall_1), .halted(halted_1)
  );

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] hash(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: real data only in the last enabled cycle, junk before it.
  int en_cnt, en_cnt_1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_cnt   <= 0;
      en_cnt_1 <= 0;
    end else begin
      en_cnt   <= mem_en   ? en_cnt + 1   : 0;
      en_cnt_1 <= mem_en_1 ? en_cnt_1 + 1 : 0;
    end
  end
  assign mem_rdata   = (mem_en   && en_cnt   == L - 1) ? hash(mem_addr)   : (32'hBAD0_0000 | 32'(en_cnt));
  assign mem_rdata_1 = (mem_en_1 && en_cnt_1 == 0)     ? hash(mem_addr_1) : 32'hBAD1_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0;
    d_wdata = 0; d_funct3 = 0; halt_in = 0;
    if_req_1 = 0; if_addr_1 = 0; d_read_1 = 0; d_write_1 = 0; d_addr_1 = 0;
    d_wdata_1 = 0; d_funct3_1 = 0; halt_in_1 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  // An access granted at edge g keeps the port for edges g..g+L-1 and its
  // ready shows after edge g+L; the port is free again from edge g+L+1.
  bit          m_busy, m_data, m_we, m_last_data, m_halted, m_hseen;
  int          m_g;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_f3;
  bit          e_if_rdy, e_d_rdy;
  logic [31:0] e_if_rdata, e_d_rdata;

  task automatic model_reset();
    m_busy = 0; m_last_data = 0; m_halted = 0; m_hseen = 0;
    e_if_rdy = 0; e_d_rdy = 0;
  endtask

  task automatic model_step(input int n);
    bit dq;
    dq = d_read | d_write;
    e_if_rdy = 0;
    e_d_rdy  = 0;
    if (m_halted) return;
    if (m_busy) begin
      if (halt_in) m_hseen = 1;
      if (n == m_g + L) begin
        m_busy = 0;
        if (m_data) begin e_d_rdy = 1; e_d_rdata = hash(m_addr); end
        else        begin e_if_rdy = 1; e_if_rdata = hash(m_addr); end
        m_last_data = m_data;
        if (m_hseen) m_halted = 1;
      end
    end else if (halt_in) begin
      m_halted = 1;
    end else if (if_req || dq) begin
      m_data  = dq && (!if_req || !m_last_data);
      m_busy  = 1;
      m_g     = n;
      m_hseen = 0;
      if (m_data) begin
        m_addr = d_addr; m_wdata = d_wdata; m_f3 = d_funct3; m_we = d_write;
      end else begin
        m_addr = if_addr; m_f3 = 3'b010; m_we = 0;
      end
    end
  endtask

  typedef struct {
    logic        d_read;
    logic [31:0] d_addr;
    logic        exp_stall;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_rdy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tv[5];

  initial begin
    // MEM_LAT=1 back-to-back loads: 0x0 then 0x4, each done in 2 cycles.
    tv[0] = '{1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_FFFF};
    tv[2] = '{1'b1, 32'h4, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
    tv[3] = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0004_FFFB};
    tv[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};

    rst = 1'b1;
    clear_inputs();
    #2;
    check("reset mem_en", mem_en, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_funct3", mem_funct3, 3'b010);
    check("reset mem_addr", mem_addr, 0);
    check("reset stall", stall, 0);
    check("reset halted", halted, 0);
    check("reset if_ready", if_ready, 0);
    check("reset d_ready", d_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // ---- single fetch ----
    if_req = 1; if_addr = 32'h100;
    #1 check("fetch stall while waiting", stall, 1);
    cyc();
    check("fetch en c1", mem_en, 1);
    check("fetch addr c1", mem_addr, 32'h100);
    check("fetch funct3", mem_funct3, 3'b010);
    check("fetch we", mem_we, 0);
    check("fetch no early ready", if_ready, 0);
    cyc();
    check("fetch en c2", mem_en, 1);
    check("fetch addr c2", mem_addr, 32'h100);
    cyc();
    check("fetch en off", mem_en, 0);
    check("fetch if_ready", if_ready, 1);
    check("fetch if_rdata", if_rdata, 32'h0050_0093);
    check("fetch stall drop", stall, 0);
    if_req = 0;
    cyc();
    check("fetch ready one pulse", if_ready, 0);

    // ---- tie from reset, then round-robin ----
    do_reset();
    if_req = 1; if_addr = 32'h200; d_read = 1; d_addr = 32'h300; d_funct3 = 3'b100;
    cyc();
    check("tie1 data first addr", mem_addr, 32'h300);
    check("tie1 data we", mem_we, 0);
    check("tie1 data funct3", mem_funct3, 3'b100);
    check("tie1 en", mem_en, 1);
    cyc(); cyc();
    check("tie1 d_ready", d_ready, 1);
    check("tie1 d_rdata", d_rdata, 32'h0300_FCFF);
    check("tie1 bubble", mem_en, 0);
    check("tie1 stall fetch waits", stall, 1);
    d_addr = 32'h304;
    cyc();
    check("tie2 fetch wins addr", mem_addr, 32'h200);
    check("tie2 funct3 word", mem_funct3, 3'b010);
    cyc(); cyc();
    check("tie2 if_ready", if_ready, 1);
    check("tie2 if_rdata", if_rdata, 32'h0200_FDFF);
    if_addr = 32'h204;
    cyc();
    check("tie3 data wins addr", mem_addr, 32'h304);
    cyc(); cyc();
    check("tie3 d_rdata", d_rdata, 32'h0304_FCFB);
    d_read = 0;
    cyc();
    check("tie4 fetch addr", mem_addr, 32'h204);
    cyc(); cyc();
    check("tie4 if_rdata", if_rdata, 32'h0204_FDFB);
    if_req = 0;
    cyc();

    // ---- store ----
    d_write = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("store en", mem_en, 1);
      check("store we", mem_we, 1);
      check("store addr", mem_addr, 32'h40);
      check("store wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    cyc();
    check("store d_ready", d_ready, 1);
    check("store en off", mem_en, 0);
    check("store we off", mem_we, 0);
    d_write = 0;
    cyc();

    // ---- reset mid-access ----
    if_req = 1; if_addr = 32'h500;
    cyc();
    check("rst-mid en before", mem_en, 1);
    #2 rst = 1'b1; if_req = 0;
    #1;
    check("rst-mid en async drop", mem_en, 0);
    check("rst-mid stall async drop", stall, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst-mid no ready", if_ready, 0);
      check("rst-mid en held low", mem_en, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    d_read = 1; d_addr = 32'h600;
    cyc();
    check("post-rst addr", mem_addr, 32'h600);
    cyc(); cyc();
    check("post-rst d_ready", d_ready, 1);
    check("post-rst d_rdata", d_rdata, 32'h0600_F9FF);
    d_read = 0;
    cyc();

    // ---- MEM_LAT=1 vector table ----
    for (int i = 0; i < 5; i++) begin
      d_read_1 = tv[i].d_read;
      d_addr_1 = tv[i].d_addr;
      #1 check($sformatf("lat1[%0d] stall", i), stall_1, tv[i].exp_stall);
      cyc();
      check($sformatf("lat1[%0d] en", i), mem_en_1, tv[i].exp_en);
      if (tv[i].exp_en) check($sformatf("lat1[%0d] addr", i), mem_addr_1, tv[i].exp_addr);
      check($sformatf("lat1[%0d] ready", i), d_ready_1, tv[i].exp_rdy);
      if (tv[i].exp_rdy) check($sformatf("lat1[%0d] rdata", i), d_rdata_1, tv[i].exp_rdata);
    end

    // ---- randomized traffic vs model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      int k;
      @(posedge clk);
      model_step(c);
      #1;
      check("rnd mem_en", mem_en, m_busy);
      check("rnd mem_we", mem_we, m_busy & m_we);
      if (m_busy) begin
        check("rnd mem_addr", mem_addr, m_addr);
        check("rnd mem_funct3", mem_funct3, m_f3);
        if (m_we) check("rnd mem_wdata", mem_wdata, m_wdata);
      end
      check("rnd if_ready", if_ready, e_if_rdy);
      check("rnd d_ready", d_ready, e_d_rdy);
      if (e_if_rdy) check("rnd if_rdata", if_rdata, e_if_rdata);
      if (e_d_rdy)  check("rnd d_rdata", d_rdata, e_d_rdata);
      check("rnd halted", halted, m_halted);

      if (!if_req || if_ready) begin
        if_req  = $urandom_range(0, 1) == 1;
        if_addr = 32'($urandom_range(0, 1023)) << 2;
      end else if ($urandom_range(0, 49) == 0) begin
        if_req = 0;
      end
      if (!(d_read || d_write) || d_ready) begin
        k = $urandom_range(0, 9);
        d_read   = (k < 4) || (k == 7);
        d_write  = (k >= 4 && k < 8);
        d_addr   = 32'($urandom_range(0, 1023)) << 2;
        d_wdata  = $urandom;
        d_funct3 = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 49) == 0) begin
        d_read = 0; d_write = 0;
      end
      halt_in = (c > 1300) && ($urandom_range(0, 19) == 0);
      #1;
      check("rnd stall", stall,
            m_halted | (if_req & ~e_if_rdy) | ((d_read | d_write) & ~e_d_rdy));
    end

    // ---- halt during a fetch ----
    do_reset();
    if_req = 1; if_addr = 32'h700;
    cyc();
    halt_in = 1;
    cyc();
    halt_in = 0;
    check("halt not yet", halted, 0);
    cyc();
    check("halt if_ready", if_ready, 1);
    check("halt if_rdata", if_rdata, 32'h0700_F8FF);
    check("halt halted", halted, 1);
    check("halt stall", stall, 1);
    if_addr = 32'h800; d_read = 1; d_addr = 32'h900;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("halted no mem_en", mem_en, 0);
      check("halted sticky", halted, 1);
      check("halted stall", stall, 1);
      check("halted no if_ready", if_ready, 0);
      check("halted no d_ready", d_ready, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
